axis_stream_arbiter: RTL and testbench

Round-robin arbiter that merges `num_inputs` AXI-stream producers (waveform loaders, PS command paths) onto one stream that feeds a single `axis_sync_fifo` instance. Grants are held for bursts of up to `burst_len` beats, so one producer cannot starve the others. The arbiter tags every output beat with its source index so downstream logic can demultiplex. It sits between the PS-side producers and the shared playback FIFO in the `axis_clk` domain.

---
 rtl/axis_stream_arbiter_pkg.sv | 15 +
 rtl/axis_stream_arbiter_rr_select.sv | 44 ++++
 rtl/axis_stream_arbiter.sv | 130 +++++++++++++
 tb/tb_axis_stream_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_stream_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_stream_arbiter_pkg
// Brief    : Shared types and constants for the AXI-stream round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package axis_stream_arbiter_pkg;

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

   localparam int c_arb_max_inputs    = 16;
   localparam int c_arb_default_burst = 16;

endpackage
`default_nettype wire

// File: rtl/axis_stream_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_select
// Brief    : Rotate-and-find-first over a request vector, starting after last_grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_select #(
   parameter int NUM_INPUTS = 4,
   parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
   input  logic [NUM_INPUTS-1:0] req,
   input  logic [SEL_WIDTH-1:0]  last_grant,
   output logic [SEL_WIDTH-1:0]  idx,
   output logic                  any
);

   logic [2*NUM_INPUTS-1:0] w_req_dbl;
   logic [2*NUM_INPUTS-1:0] w_req_rot;
   logic [SEL_WIDTH:0]      w_shift;
   int                      w_pos;
   int                      w_sum;

   // Doubling the vector turns the modular scan into a plain right shift.
   assign w_req_dbl = {req, req};
   assign w_shift   = {1'b0, last_grant} + 1'b1;
   assign w_req_rot = w_req_dbl >> w_shift;

   always_comb begin
      w_pos = 0;
      for (int p = NUM_INPUTS - 1; p >= 0; p--) begin
         if (w_req_rot[p]) begin
            w_pos = p;
         end
      end
      w_sum = int'(w_shift) + w_pos;
      if (w_sum >= NUM_INPUTS) begin
         w_sum = w_sum - NUM_INPUTS;
      end
      idx = SEL_WIDTH'(w_sum);
      any = |req;
   end

endmodule
`default_nettype wire

// File: rtl/axis_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axis_stream_arbiter
// Brief    : Round-robin burst arbiter merging several AXI streams, tagging each beat with its source.
// Revision : 1.0 - initial release
// ============================================================================
module axis_stream_arbiter
   import axis_stream_arbiter_pkg::*;
#(
   parameter int NUM_INPUTS = 4,
   parameter int BUS_WIDTH  = 256,
   parameter int BURST_LEN  = c_arb_default_burst,
   parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
   input  logic                            axis_clk,
   input  logic                            rst,
   input  logic [NUM_INPUTS-1:0]           s_axis_tvalid,
   output logic [NUM_INPUTS-1:0]           s_axis_tready,
   input  logic [NUM_INPUTS*BUS_WIDTH-1:0] s_axis_tdata,
   output logic [BUS_WIDTH-1:0]            m_axis_tdata,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [SEL_WIDTH-1:0]            m_axis_tsel,
   output logic                            grant_active
);

   if (NUM_INPUTS < 2 || NUM_INPUTS > c_arb_max_inputs || BURST_LEN < 1 || BURST_LEN > 256) begin : g_param_check
      $error("axis_stream_arbiter: parameter out of range");
   end

   arb_state_t             r_state;
   logic [SEL_WIDTH-1:0]   r_grant;
   logic [SEL_WIDTH-1:0]   r_last_grant;
   logic [7:0]             r_beat_cnt;
   logic [BUS_WIDTH-1:0]   r_m_tdata;
   logic                   r_m_tvalid;
   logic [SEL_WIDTH-1:0]   r_m_tsel;
   logic                   r_grant_active;

   logic [SEL_WIDTH-1:0]   w_sel_idx;
   logic                   w_sel_any;
   logic                   w_stage_ready;
   logic                   w_grant_valid;
   logic [BUS_WIDTH-1:0]   w_grant_data;
   logic                   w_accept;
   logic                   w_last_beat;

   rr_priority_select #(
      .NUM_INPUTS (NUM_INPUTS),
      .SEL_WIDTH  (SEL_WIDTH)
   ) u_rr_select (
      .req        (s_axis_tvalid),
      .last_grant (r_last_grant),
      .idx        (w_sel_idx),
      .any        (w_sel_any)
   );

   assign w_stage_ready = !r_m_tvalid || m_axis_tready;

   // Ready is gated by state and output-stage occupancy only, never by tvalid.
   always_comb begin
      w_grant_valid = 1'b0;
      w_grant_data  = '0;
      s_axis_tready = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (r_grant == SEL_WIDTH'(i)) begin
            w_grant_valid    = s_axis_tvalid[i];
            w_grant_data     = s_axis_tdata[i*BUS_WIDTH +: BUS_WIDTH];
            s_axis_tready[i] = (r_state == ARB_GRANT) && w_stage_ready;
         end
      end
   end

   assign w_accept    = (r_state == ARB_GRANT) && w_grant_valid && w_stage_ready;
   assign w_last_beat = (r_beat_cnt == 8'(BURST_LEN - 1));

   always_ff @(posedge axis_clk or negedge rst) begin
      if (!rst) begin
         r_state        <= ARB_IDLE;
         r_grant        <= '0;
         r_last_grant   <= SEL_WIDTH'(NUM_INPUTS - 1);
         r_beat_cnt     <= '0;
         r_m_tdata      <= '0;
         r_m_tvalid     <= 1'b0;
         r_m_tsel       <= '0;
         r_grant_active <= 1'b0;
      end else begin
         if (w_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_grant_data;
            r_m_tsel   <= r_grant;
         end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
         end

         case (r_state)
            ARB_IDLE: begin
               if (w_sel_any) begin
                  r_grant        <= w_sel_idx;
                  r_beat_cnt     <= '0;
                  r_state        <= ARB_GRANT;
                  r_grant_active <= 1'b1;
               end
            end
            ARB_GRANT: begin
               if (w_accept) begin
                  r_beat_cnt <= r_beat_cnt + 8'd1;
               end
               // A completed burst or a source gap both hand the bus back.
               if ((w_accept && w_last_beat) || !w_grant_valid) begin
                  r_state        <= ARB_IDLE;
                  r_last_grant   <= r_grant;
                  r_grant_active <= 1'b0;
               end
            end
            default: begin
               r_state        <= ARB_IDLE;
               r_grant_active <= 1'b0;
            end
         endcase
      end
   end

   assign m_axis_tdata  = r_m_tdata;
   assign m_axis_tvalid = r_m_tvalid;
   assign m_axis_tsel   = r_m_tsel;
   assign grant_active  = r_grant_active;

endmodule
`default_nettype wire

// File: tb/tb_axis_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_stream_arbiter
// Brief    : Self-checking bench for axis_stream_arbiter at burst lengths 16, 4 and 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_stream_arbiter;

   localparam int NI = 4;
   localparam int BW = 32;
   localparam int SW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst      [3];
   logic [NI-1:0]  s_tvalid [3];
   logic [NI-1:0]  s_tready [3];
   logic [NI*BW-1:0] s_tdata [3];
   logic [BW-1:0]  m_tdata  [3];
   logic           m_tvalid [3];
   logic           m_tready [3];
   logic [SW-1:0]  m_tsel   [3];
   logic           gact     [3];

   int n_checks = 0;
   int n_fail   = 0;

   axis_stream_arbiter #(.NUM_INPUTS(NI), .BUS_WIDTH(BW), .BURST_LEN(16)) u_dut_a (
      .axis_clk(clk), .rst(rst[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
      .s_axis_tdata(s_tdata[0]), .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]),
      .m_axis_tready(m_tready[0]), .m_axis_tsel(m_tsel[0]), .grant_active(gact[0]));

   axis_stream_arbiter #(.NUM_INPUTS(NI), .BUS_WIDTH(BW), .BURST_LEN(4)) u_dut_b (
      .axis_clk(clk), .rst(rst[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
      .s_axis_tdata(s_tdata[1]), .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]),
      .m_axis_tready(m_tready[1]), .m_axis_tsel(m_tsel[1]), .grant_active(gact[1]));

   axis_stream_arbiter #(.NUM_INPUTS(NI), .BUS_WIDTH(BW), .BURST_LEN(1)) u_dut_c (
      .axis_clk(clk), .rst(rst[2]), .s_axis_tvalid(s_tvalid[2]), .s_axis_tready(s_tready[2]),
      .s_axis_tdata(s_tdata[2]), .m_axis_tdata(m_tdata[2]), .m_axis_tvalid(m_tvalid[2]),
      .m_axis_tready(m_tready[2]), .m_axis_tsel(m_tsel[2]), .grant_active(gact[2]));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Cycle-level vectors: inputs applied after a rising edge, outputs sampled on the falling edge.
   typedef struct {
      logic          rst;
      logic [NI-1:0] tv;
      logic          mr;
      logic [NI-1:0] e_rdy;
      logic          e_mtv;
      logic [SW-1:0] e_sel;
      logic          e_ga;
      logic [BW-1:0] e_data;
   } vec_t;

   vec_t tbl [16];

   // Source queues and captured output beats for the stream engine.
   logic [BW-1:0] q [NI][$];
   logic [BW-1:0] out_data [$];
   logic [SW-1:0] out_sel  [$];
   int            out_cyc  [$];

   task automatic pulse_reset(input int k);
      @(posedge clk); #1;
      rst[k]      = 1'b0;
      s_tvalid[k] = '0;
      m_tready[k] = 1'b1;
      @(posedge clk); #1;
      rst[k]      = 1'b1;
   endtask

   task automatic run_engine(input int k, input int mr_pct, input int max_cyc);
      int            cyc;
      int            pending;
      logic          stalled;
      logic [BW-1:0] held;
      logic [NI-1:0] hs;
      cyc     = 0;
      stalled = 1'b0;
      held    = '0;
      out_data.delete();
      out_sel.delete();
      out_cyc.delete();
      while (1) begin
         pending = 0;
         for (int i = 0; i < NI; i++) pending += q[i].size();
         if (pending == 0 && !m_tvalid[k]) break;
         if (cyc >= max_cyc) begin
            check("engine_timeout_pending", 64'(pending), 64'd0);
            break;
         end
         for (int i = 0; i < NI; i++) begin
            s_tvalid[k][i] = (q[i].size() != 0);
            s_tdata[k][i*BW +: BW] = (q[i].size() != 0) ? q[i][0] : '0;
         end
         m_tready[k] = ($urandom_range(99) < mr_pct);
         @(negedge clk);
         check("tready_onehot0", 64'($countones(s_tready[k]) <= 1), 64'd1);
         if (stalled) begin
            check("stall_hold_valid", 64'(m_tvalid[k]), 64'd1);
            check("stall_hold_data", 64'(m_tdata[k]), 64'(held));
         end
         stalled = m_tvalid[k] && !m_tready[k];
         held    = m_tdata[k];
         if (stalled) check("stall_ready_low", 64'(s_tready[k]), 64'd0);
         hs = s_tvalid[k] & s_tready[k];
         if (m_tvalid[k] && m_tready[k]) begin
            out_data.push_back(m_tdata[k]);
            out_sel.push_back(m_tsel[k]);
            out_cyc.push_back(cyc);
         end
         @(posedge clk); #1;
         for (int i = 0; i < NI; i++) if (hs[i]) void'(q[i].pop_front());
         cyc++;
      end
      s_tvalid[k] = '0;
      m_tready[k] = 1'b1;
   endtask

   // Transaction-level model: every source holds all its beats from the start, so grants
   // rotate over non-empty sources taking min(burst, remaining) beats each.
   task automatic model_test(input string tag, input int k, input int bl,
                             input int cnt [NI], input int mr_pct);
      int            rem [NI];
      int            last, idx, n, any_left, nxt_gap, lim;
      logic [SW-1:0] e_sel  [$];
      logic [BW-1:0] e_data [$];
      int            e_gap  [$];
      pulse_reset(k);
      for (int i = 0; i < NI; i++) begin
         q[i].delete();
         for (int b = 0; b < cnt[i]; b++) q[i].push_back(BW'((i << 24) | (b + 1)));
         rem[i] = cnt[i];
      end
      last    = NI - 1;
      nxt_gap = 0;
      any_left = 1;
      while (any_left != 0) begin
         idx = -1;
         for (int off = 1; off <= NI; off++) begin
            if (idx < 0 && rem[(last + off) % NI] > 0) idx = (last + off) % NI;
         end
         if (idx < 0) begin
            any_left = 0;
         end else begin
            n = (rem[idx] < bl) ? rem[idx] : bl;
            for (int b = 0; b < n; b++) begin
               e_sel.push_back(SW'(idx));
               e_data.push_back(BW'((idx << 24) | (cnt[idx] - rem[idx] + b + 1)));
               e_gap.push_back(b == 0 ? nxt_gap : 1);
            end
            rem[idx] -= n;
            // Burst release costs one idle cycle; a gap release adds the cycle spent seeing the gap.
            nxt_gap = (n == bl) ? 2 : 3;
            last = idx;
         end
      end
      run_engine(k, mr_pct, 2000);
      check({tag, "_beat_count"}, 64'(out_data.size()), 64'(e_data.size()));
      lim = (out_data.size() < e_data.size()) ? out_data.size() : e_data.size();
      for (int j = 0; j < lim; j++) begin
         check($sformatf("%s_sel[%0d]", tag, j), 64'(out_sel[j]), 64'(e_sel[j]));
         check($sformatf("%s_data[%0d]", tag, j), 64'(out_data[j]), 64'(e_data[j]));
         if (mr_pct >= 100 && j > 0 && e_gap[j] != 0)
            check($sformatf("%s_spacing[%0d]", tag, j), 64'(out_cyc[j] - out_cyc[j-1]), 64'(e_gap[j]));
      end
   endtask

   initial begin
      int cnt [NI];

      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b0; s_tvalid[k] = '0; s_tdata[k] = '0; m_tready[k] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) rst[k] = 1'b1;

      // Reset priority, stall, gap release and asynchronous reset mid-burst on instance A.
      tbl[0]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 4'b1001, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0};
      tbl[2]  = '{1'b1, 4'b1001, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1, 32'h0};
      tbl[3]  = '{1'b1, 4'b1000, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 32'hA0};
      tbl[4]  = '{1'b1, 4'b1000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 32'hA0};
      tbl[5]  = '{1'b1, 4'b1000, 1'b0, 4'b1000, 1'b0, 2'd0, 1'b1, 32'hA0};
      tbl[6]  = '{1'b1, 4'b1000, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 32'hA3};
      tbl[7]  = '{1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 32'hA3};
      tbl[8]  = '{1'b1, 4'b0100, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 32'hA3};
      tbl[9]  = '{1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, 32'hA3};
      tbl[10] = '{1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd3, 1'b1, 32'hA3};
      tbl[11] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0};
      tbl[12] = '{1'b1, 4'b1001, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 32'h0};
      tbl[13] = '{1'b1, 4'b1001, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1, 32'h0};
      tbl[14] = '{1'b1, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 32'hA0};
      tbl[15] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 32'hA0};

      s_tdata[0] = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      for (int r = 0; r < 16; r++) begin
         @(posedge clk); #1;
         rst[0]      = tbl[r].rst;
         s_tvalid[0] = tbl[r].tv;
         m_tready[0] = tbl[r].mr;
         @(negedge clk);
         check($sformatf("vec%0d_tready", r), 64'(s_tready[0]), 64'(tbl[r].e_rdy));
         check($sformatf("vec%0d_tvalid", r), 64'(m_tvalid[0]), 64'(tbl[r].e_mtv));
         check($sformatf("vec%0d_tsel", r), 64'(m_tsel[0]), 64'(tbl[r].e_sel));
         check($sformatf("vec%0d_grant_active", r), 64'(gact[0]), 64'(tbl[r].e_ga));
         check($sformatf("vec%0d_tdata", r), 64'(m_tdata[0]), 64'(tbl[r].e_data));
      end
      @(posedge clk); #1;
      rst[0] = 1'b1;
      s_tvalid[0] = '0;

      cnt = '{0, 40, 0, 0};
      model_test("single", 0, 16, cnt, 100);
      cnt = '{8, 8, 8, 8};
      model_test("fair", 1, 4, cnt, 100);
      cnt = '{0, 0, 3, 5};
      model_test("gap", 0, 16, cnt, 100);
      cnt = '{16, 0, 0, 0};
      model_test("backpressure", 0, 16, cnt, 50);
      cnt = '{4, 0, 4, 0};
      model_test("burst1", 2, 1, cnt, 100);
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < NI; i++) cnt[i] = int'($urandom_range(12, 1));
         model_test($sformatf("rand%0d", t), 1, 4, cnt, 60);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
